// File: rtl/button_event_arbiter.sv
// Push-button front end: 2-FF sync, tick-based debounce, per-channel event queueing, round-robin event port.
// Optional long-press events are enabled by defining BUTTON_EVENT_LONG_PRESS_EN.
module button_event_arbiter #(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 1000000,
    parameter int STABLE_TICKS = 3,
    parameter int LONG_TICKS   = 50
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn_raw,
    output logic [N_BTN-1:0]         btn_level,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_long,
    output logic [N_BTN-1:0]         overrun,
    output logic                     dbg_state
);
    localparam int ID_W  = $clog2(N_BTN);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W  = $clog2(STABLE_TICKS + 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [N_BTN-1:0] sync1, sync2;
    logic [DB_W-1:0]  db_cnt [N_BTN];
    logic [N_BTN-1:0] press_pend, press_set, press_clr, press_drop;
    logic [N_BTN-1:0] long_pend, long_drop;
    logic [N_BTN-1:0] req;
    logic [ID_W-1:0]  rr_ptr, gnt_id, cand;
    logic             any_req, gnt_long, take, load;
    int               idx;

    assign dbg_state = state;
    assign tick      = (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            sync1    <= '0;
            sync2    <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            sync1    <= btn_raw;
            sync2    <= sync1;
        end
    end

    // Level toggles on the STABLE_TICKS-th consecutive differing sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level <= '0;
            for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2[i] != btn_level[i]) begin
                    if (db_cnt[i] == DB_W'(STABLE_TICKS - 1)) begin
                        btn_level[i] <= ~btn_level[i];
                        db_cnt[i]    <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        press_set = '0;
        press_clr = '0;
        for (int i = 0; i < N_BTN; i++) begin
            press_set[i] = tick && sync2[i] && !btn_level[i] &&
                           (db_cnt[i] == DB_W'(STABLE_TICKS - 1));
            press_clr[i] = load && !gnt_long && (gnt_id == ID_W'(i));
        end
    end

    // A set coinciding with the clear of the same bit simply re-queues it.
    assign press_drop = press_set & press_pend & ~press_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_pend <= '0;
            overrun    <= '0;
        end else begin
            press_pend <= (press_pend & ~press_clr) | press_set;
            overrun    <= press_drop | long_drop;
        end
    end

`ifdef BUTTON_EVENT_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);
    logic [HOLD_W-1:0] hold_cnt [N_BTN];
    logic [N_BTN-1:0]  long_set, long_clr;

    always_comb begin
        long_set = '0;
        long_clr = '0;
        for (int i = 0; i < N_BTN; i++) begin
            long_set[i] = tick && btn_level[i] && (hold_cnt[i] == HOLD_W'(LONG_TICKS - 1));
            long_clr[i] = load && gnt_long && (gnt_id == ID_W'(i));
        end
    end

    assign long_drop = long_set & long_pend & ~long_clr;

    // Hold counter saturates, so long_set fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) hold_cnt[i] <= '0;
            long_pend <= '0;
            evt_long  <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!btn_level[i])
                    hold_cnt[i] <= '0;
                else if (tick && hold_cnt[i] < HOLD_W'(LONG_TICKS))
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
            end
            long_pend <= (long_pend & ~long_clr) | long_set;
            if (load) evt_long <= gnt_long;
        end
    end
`else
    assign long_pend = '0;
    assign long_drop = '0;
    assign evt_long  = 1'b0;
`endif

    assign req = press_pend | long_pend;

    always_comb begin
        any_req = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        idx     = 0;
        for (int k = 0; k < N_BTN; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_BTN) idx = idx - N_BTN;
            cand = ID_W'(idx);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    assign gnt_long = !press_pend[gnt_id];

    // Event port: an event transfers on a clk edge where evt_valid && evt_ready;
    // while evt_valid is high and evt_ready low, evt_id/evt_long stay stable.
    assign take = (state == ST_IDLE) || evt_ready;
    assign load = take && any_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            state     <= ST_PRESENT;
            evt_valid <= 1'b1;
            evt_id    <= gnt_id;
            rr_ptr    <= (gnt_id == ID_W'(N_BTN - 1)) ? '0 : gnt_id + 1'b1;
        end else if (state == ST_PRESENT && evt_ready) begin
            state     <= ST_IDLE;
            evt_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter (N_BTN=4, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=5).
// Long-press scenario runs only when BUTTON_EVENT_LONG_PRESS_EN is defined.
module tb_button_event_arbiter;
    localparam int N_BTN = 4;
    localparam int ID_W  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      btn_raw = '0;
    logic            evt_ready = 1'b0;
    logic [3:0]      btn_level;
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_long;
    logic [3:0]      overrun;
    logic            dbg_state;

    int total = 0;
    int bad   = 0;
    logic [ID_W:0] exp_q[$];
    logic [ID_W:0] got_q[$];
    int ov_cnt[N_BTN] = '{default: 0};

    button_event_arbiter #(
        .N_BTN(4), .TICK_DIV(4), .STABLE_TICKS(3), .LONG_TICKS(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_long(evt_long), .overrun(overrun), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Accepted events and overrun pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (evt_valid && evt_ready) got_q.push_back({evt_long, evt_id});
        for (int i = 0; i < N_BTN; i++) if (overrun[i]) ov_cnt[i]++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic wait_level(input int ch, input logic val, input int budget,
                              output logic ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            if (btn_level[ch] === val) begin
                ok = 1'b1;
                cycles = c;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int budget, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (evt_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic ok;
        int cyc;
        logic [ID_W:0] g;
        logic [ID_W:0] e;
        rst_n = 1'b0; btn_raw = 4'hF; evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (btn_level !== 4'h0) begin bad++; $display("FAIL rst_level got=%h exp=0", btn_level); end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", evt_valid); end
        total++; if (evt_id !== 2'd0) begin bad++; $display("FAIL rst_id got=%0d exp=0", evt_id); end
        total++; if (evt_long !== 1'b0) begin bad++; $display("FAIL rst_long got=%b exp=0", evt_long); end
        total++; if (overrun !== 4'h0) begin bad++; $display("FAIL rst_overrun got=%h exp=0", overrun); end
        rst_n = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        total++; if (btn_level !== 4'h0) begin bad++; $display("FAIL rst_level_early got=%h exp=0", btn_level); end
        @(posedge clk); #1;
        total++; if (btn_level !== 4'hF) begin bad++; $display("FAIL rst_level_3ticks got=%h exp=f", btn_level); end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid_lat got=%b exp=0", evt_valid); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++;
            if (evt_valid !== 1'b1 || evt_id !== ID_W'(i)) begin
                bad++; $display("FAIL rst_seq[%0d] got=%b/%0d exp=1/%0d", i, evt_valid, evt_id, i);
            end
            exp_q.push_back({1'b0, ID_W'(i)});
        end
        @(posedge clk); #1;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rst_seq_end got=%b exp=0", evt_valid); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rst_evt_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL rst_evt got=%b exp=%b", g, e); end
        end
        btn_raw = 4'h0;
        for (int i = 0; i < 4; i++) begin
            wait_level(i, 1'b0, 40, ok, cyc);
            total++; if (!ok) begin bad++; $display("FAIL rst_release[%0d] got=%b exp=0", i, btn_level[i]); end
        end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL rst_release_evt got=%0d exp=0", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_round_robin();
        logic ok;
        logic stable;
        int cyc;
        logic [ID_W:0] g;
        logic [ID_W:0] e;
        evt_ready = 1'b0;
        btn_raw = 4'b0101;
        wait_valid(60, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_valid got=0 exp=1"); end
        total++; if (evt_id !== 2'd0) begin bad++; $display("FAIL rr_first got=%0d exp=0", evt_id); end
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_long !== 1'b0) stable = 1'b0;
        end
        total++; if (!stable) begin bad++; $display("FAIL rr_hold got=%b/%0d exp=1/0", evt_valid, evt_id); end
        evt_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin bad++; $display("FAIL rr_b2b got=%b/%0d exp=1/2", evt_valid, evt_id); end
        @(posedge clk); #1;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b exp=0", evt_valid); end
        exp_q.push_back({1'b0, 2'd0});
        exp_q.push_back({1'b0, 2'd2});
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rr_evt_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL rr_evt got=%b exp=%b", g, e); end
        end
        got_q.delete();
        btn_raw = 4'h0;
        wait_level(0, 1'b0, 40, ok, cyc);
        wait_level(2, 1'b0, 40, ok, cyc);
        total++; if (btn_level !== 4'h0) begin bad++; $display("FAIL rr_release got=%h exp=0", btn_level); end
    endtask

    task automatic test_bounce();
        logic ok;
        logic steady;
        int cyc;
        logic [ID_W:0] g;
        logic [ID_W:0] e;
        evt_ready = 1'b1;
        btn_raw[1] = 1'b1;
        steady = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (t > 0 && t % 5 == 0) btn_raw[1] = ~btn_raw[1];
            @(posedge clk); #1;
            if (btn_level[1] !== 1'b0) steady = 1'b0;
        end
        total++; if (!steady) begin bad++; $display("FAIL bounce_steady got=1 exp=0"); end
        btn_raw[1] = 1'b1;
        wait_level(1, 1'b1, 20, ok, cyc);
        total++;
        if (!ok || cyc < 10 || cyc > 13) begin
            bad++; $display("FAIL bounce_rise_cycles got=%0d exp=10..13", cyc);
        end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL bounce_pend_lat got=%b exp=0", evt_valid); end
        @(posedge clk); #1;
        total++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin bad++; $display("FAIL bounce_evt got=%b/%0d exp=1/1", evt_valid, evt_id); end
        repeat (5) @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 2'd1});
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bounce_evt_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL bounce_evt_id got=%b exp=%b", g, e); end
        end
        got_q.delete();
        btn_raw[1] = 1'b0;
        wait_level(1, 1'b0, 40, ok, cyc);
        total++; if (!ok || got_q.size() != 0) begin bad++; $display("FAIL bounce_release got=%b/%0d exp=0/0", btn_level[1], got_q.size()); end
    endtask

    task automatic press_release(input int ch, output logic ok);
        logic ok_a;
        logic ok_b;
        int cyc;
        btn_raw[ch] = 1'b1;
        wait_level(ch, 1'b1, 40, ok_a, cyc);
        btn_raw[ch] = 1'b0;
        wait_level(ch, 1'b0, 40, ok_b, cyc);
        ok = ok_a && ok_b;
    endtask

    task automatic test_overrun();
        logic ok;
        int base [N_BTN];
        logic [ID_W:0] g;
        logic [ID_W:0] e;
        for (int i = 0; i < N_BTN; i++) base[i] = ov_cnt[i];
        evt_ready = 1'b0;
        press_release(0, ok);
        total++; if (!ok || evt_valid !== 1'b1 || evt_id !== 2'd0) begin bad++; $display("FAIL ov_slot got=%b/%0d exp=1/0", evt_valid, evt_id); end
        press_release(3, ok);
        total++; if (!ok) begin bad++; $display("FAIL ov_press1 got=0 exp=1"); end
        press_release(3, ok);
        total++; if (!ok) begin bad++; $display("FAIL ov_press2 got=0 exp=1"); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (ov_cnt[3] - base[3] != 1) begin bad++; $display("FAIL ov_pulses got=%0d exp=1", ov_cnt[3] - base[3]); end
        total++;
        if ((ov_cnt[0] - base[0]) + (ov_cnt[1] - base[1]) + (ov_cnt[2] - base[2]) != 0) begin
            bad++; $display("FAIL ov_other got=%0d exp=0", (ov_cnt[0] - base[0]) + (ov_cnt[1] - base[1]) + (ov_cnt[2] - base[2]));
        end
        total++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin bad++; $display("FAIL ov_hold got=%b/%0d exp=1/0", evt_valid, evt_id); end
        evt_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL ov_drain got=%b exp=0", evt_valid); end
        exp_q.push_back({1'b0, 2'd0});
        exp_q.push_back({1'b0, 2'd3});
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ov_evt_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL ov_evt got=%b exp=%b", g, e); end
        end
        got_q.delete();
    endtask

`ifdef BUTTON_EVENT_LONG_PRESS_EN
    task automatic test_long_press();
        logic ok;
        int cyc;
        logic [ID_W:0] g;
        logic [ID_W:0] e;
        evt_ready = 1'b1;
        btn_raw[0] = 1'b1;
        wait_level(0, 1'b1, 40, ok, cyc);
        total++; if (!ok) begin bad++; $display("FAIL long_rise got=0 exp=1"); end
        repeat (40) @(posedge clk);
        btn_raw[0] = 1'b0;
        wait_level(0, 1'b0, 40, ok, cyc);
        repeat (4) @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 2'd0});
        exp_q.push_back({1'b1, 2'd0});
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL long_evt_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL long_evt got=%b exp=%b", g, e); end
        end
        got_q.delete();
    endtask
`endif

    task automatic test_reset_mid();
        logic ok;
        logic quiet;
        evt_ready = 1'b0;
        press_release(2, ok);
        total++; if (!ok || evt_valid !== 1'b1 || evt_id !== 2'd2) begin bad++; $display("FAIL mid_present got=%b/%0d exp=1/2", evt_valid, evt_id); end
        press_release(1, ok);
        total++; if (!ok || evt_valid !== 1'b1 || evt_id !== 2'd2) begin bad++; $display("FAIL mid_hold got=%b/%0d exp=1/2", evt_valid, evt_id); end
        rst_n = 1'b0;
        #1;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b exp=0", evt_valid); end
        total++; if (evt_id !== 2'd0 || dbg_state !== 1'b0) begin bad++; $display("FAIL mid_async_id got=%0d/%b exp=0/0", evt_id, dbg_state); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        evt_ready = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (evt_valid !== 1'b0) quiet = 1'b0;
        end
        total++; if (!quiet || got_q.size() != 0) begin bad++; $display("FAIL mid_stale got=%b/%0d exp=1/0", quiet, got_q.size()); end
        got_q.delete();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_bounce();
        test_overrun();
`ifdef BUTTON_EVENT_LONG_PRESS_EN
        test_long_press();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
